// File: rtl/ps2_key_decoder.sv
// rtl/ps2_key_decoder.sv - PS/2 set-2 deframer and one-hot tracker for keys A-Z and 0-9 (optional PS2_PARITY_CHECK_EN)
module ps2_key_decoder #(
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [35:0] keys_code,
    output logic        key_strobe,
    output logic        frame_err
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

`ifdef PS2_PARITY_CHECK_EN
    localparam logic PARITY_EN = 1'b1;
`else
    localparam logic PARITY_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } state_t;

    logic          clk_s1_q, clk_s2_q, clk_prev_q;
    logic          data_s1_q, data_s2_q;
    state_t        state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          parity_q, parity_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic          brk_q, brk_d;
    logic          ext_q, ext_d;
    logic [35:0]   keys_code_q, keys_code_d;
    logic          key_strobe_q, key_strobe_d;
    logic          frame_err_q, frame_err_d;

    logic          fall;
    logic          parity_bad;
    logic [6:0]    key_lu;
    logic [35:0]   key_oh;

    // Set-2 scan code to key index; bit 6 flags a tracked key.
    function automatic logic [6:0] key_lookup(input logic [7:0] code);
        logic [6:0] r;
        r = 7'd0;
        case (code)
            8'h1C: r = {1'b1, 6'd0};
            8'h32: r = {1'b1, 6'd1};
            8'h21: r = {1'b1, 6'd2};
            8'h23: r = {1'b1, 6'd3};
            8'h24: r = {1'b1, 6'd4};
            8'h2B: r = {1'b1, 6'd5};
            8'h34: r = {1'b1, 6'd6};
            8'h33: r = {1'b1, 6'd7};
            8'h43: r = {1'b1, 6'd8};
            8'h3B: r = {1'b1, 6'd9};
            8'h42: r = {1'b1, 6'd10};
            8'h4B: r = {1'b1, 6'd11};
            8'h3A: r = {1'b1, 6'd12};
            8'h31: r = {1'b1, 6'd13};
            8'h44: r = {1'b1, 6'd14};
            8'h4D: r = {1'b1, 6'd15};
            8'h15: r = {1'b1, 6'd16};
            8'h2D: r = {1'b1, 6'd17};
            8'h1B: r = {1'b1, 6'd18};
            8'h2C: r = {1'b1, 6'd19};
            8'h3C: r = {1'b1, 6'd20};
            8'h2A: r = {1'b1, 6'd21};
            8'h1D: r = {1'b1, 6'd22};
            8'h22: r = {1'b1, 6'd23};
            8'h35: r = {1'b1, 6'd24};
            8'h1A: r = {1'b1, 6'd25};
            8'h45: r = {1'b1, 6'd26};
            8'h16: r = {1'b1, 6'd27};
            8'h1E: r = {1'b1, 6'd28};
            8'h26: r = {1'b1, 6'd29};
            8'h25: r = {1'b1, 6'd30};
            8'h2E: r = {1'b1, 6'd31};
            8'h36: r = {1'b1, 6'd32};
            8'h3D: r = {1'b1, 6'd33};
            8'h3E: r = {1'b1, 6'd34};
            8'h46: r = {1'b1, 6'd35};
            default: r = 7'd0;
        endcase
        return r;
    endfunction

    assign fall       = clk_prev_q & ~clk_s2_q;
    assign parity_bad = PARITY_EN & ~(^{shift_q, parity_q});
    assign key_lu     = key_lookup(shift_q);
    assign key_oh     = 36'd1 << key_lu[5:0];

    // Next-state logic: frame FSM, timeout, byte layer and key tracking.
    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        parity_d     = parity_q;
        to_cnt_d     = to_cnt_q;
        brk_d        = brk_q;
        ext_d        = ext_q;
        keys_code_d  = keys_code_q;
        key_strobe_d = 1'b0;
        frame_err_d  = 1'b0;

        if (fall) begin
            to_cnt_d = '0;
        end else if (state_q != ST_IDLE) begin
            to_cnt_d = to_cnt_q + TW'(1);
        end else begin
            to_cnt_d = '0;
        end

        case (state_q)
            ST_IDLE: begin
                if (fall) begin
                    if (!data_s2_q) begin
                        state_d   = ST_DATA;
                        bit_cnt_d = 3'd0;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
            end
            ST_DATA: begin
                if (fall) begin
                    shift_d   = {data_s2_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = ST_PARITY;
                    end
                end
            end
            ST_PARITY: begin
                if (fall) begin
                    parity_d = data_s2_q;
                    state_d  = ST_STOP;
                end
            end
            ST_STOP: begin
                if (fall) begin
                    state_d = ST_IDLE;
                    if (!data_s2_q || parity_bad) begin
                        frame_err_d = 1'b1;
                    end else if (shift_q == 8'hF0) begin
                        brk_d = 1'b1;
                    end else if (shift_q == 8'hE0) begin
                        ext_d = 1'b1;
                    end else begin
                        brk_d = 1'b0;
                        ext_d = 1'b0;
                        if (!ext_q && key_lu[6]) begin
                            if (!brk_q) begin
                                keys_code_d  = key_oh;
                                key_strobe_d = (key_oh != keys_code_q);
                            end else if (keys_code_q == key_oh) begin
                                keys_code_d = '0;
                            end
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A stalled partial frame is dropped silently.
        if (!fall && state_q != ST_IDLE && to_cnt_q == TW'(TIMEOUT_CYCLES)) begin
            state_d  = ST_IDLE;
            to_cnt_d = '0;
        end
    end

    // State registers, pin synchronizers idle high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_s1_q     <= 1'b1;
            clk_s2_q     <= 1'b1;
            clk_prev_q   <= 1'b1;
            data_s1_q    <= 1'b1;
            data_s2_q    <= 1'b1;
            state_q      <= ST_IDLE;
            bit_cnt_q    <= 3'd0;
            shift_q      <= 8'd0;
            parity_q     <= 1'b0;
            to_cnt_q     <= '0;
            brk_q        <= 1'b0;
            ext_q        <= 1'b0;
            keys_code_q  <= '0;
            key_strobe_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            clk_s1_q     <= ps2_clk;
            clk_s2_q     <= clk_s1_q;
            clk_prev_q   <= clk_s2_q;
            data_s1_q    <= ps2_data;
            data_s2_q    <= data_s1_q;
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            parity_q     <= parity_d;
            to_cnt_q     <= to_cnt_d;
            brk_q        <= brk_d;
            ext_q        <= ext_d;
            keys_code_q  <= keys_code_d;
            key_strobe_q <= key_strobe_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign keys_code  = keys_code_q;
    assign key_strobe = key_strobe_q;
    assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// tb/tb_ps2_key_decoder.sv - directed bench for ps2_key_decoder
module tb_ps2_key_decoder;

    localparam int TO = 200;

    logic        clk;
    logic        rst_n;
    logic        ps2_clk;
    logic        ps2_data;
    logic [35:0] keys_code;
    logic        key_strobe;
    logic        frame_err;

    int tests_run    = 0;
    int tests_failed = 0;
    int strobe_cnt   = 0;
    int err_cnt      = 0;
    int overlap_cnt  = 0;
    int s0, e0;

    ps2_key_decoder #(.TIMEOUT_CYCLES(TO)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .keys_code  (keys_code),
        .key_strobe (key_strobe),
        .frame_err  (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse counters sampled away from the active edge.
    always @(negedge clk) begin
        if (key_strobe) strobe_cnt <= strobe_cnt + 1;
        if (frame_err) err_cnt <= err_cnt + 1;
        if (key_strobe && frame_err) overlap_cnt <= overlap_cnt + 1;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        ps2_data = b;
        repeat (10) @(posedge clk);
        ps2_clk = 1'b0;
        repeat (10) @(posedge clk);
        ps2_clk = 1'b1;
    endtask

    // nbits < 11 sends only the leading part of the frame.
    task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic bad_stop, input int nbits);
        logic [10:0] fr;
        fr = {~bad_stop, ~(^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) send_bit(fr[i]);
        ps2_data = 1'b1;
        repeat (20) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic key(input logic [7:0] b);
        send_frame(b, 1'b0, 1'b0, 11);
    endtask

    initial begin
        rst_n    = 1'b0;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("rst_keys", 64'(keys_code), 64'h0);
        check("rst_strobe", 64'(key_strobe), 64'h0);
        check("rst_err", 64'(frame_err), 64'h0);
        rst_n = 1'b1;
        repeat (4) @(posedge clk);

        s0 = strobe_cnt;
        key(8'h1C);
        check("make_a", 64'(keys_code), 64'h1);
        check("make_a_strobe", 64'(strobe_cnt - s0), 64'd1);
        s0 = strobe_cnt;
        key(8'h1C);
        check("repeat_a", 64'(keys_code), 64'h1);
        check("repeat_a_nostrobe", 64'(strobe_cnt - s0), 64'd0);

        s0 = strobe_cnt;
        key(8'hF0);
        check("brk_prefix_hold", 64'(keys_code), 64'h1);
        key(8'h1C);
        check("break_a", 64'(keys_code), 64'h0);
        check("break_a_nostrobe", 64'(strobe_cnt - s0), 64'd0);

        s0 = strobe_cnt;
        key(8'h1C);
        key(8'h46);
        check("make_9", 64'(keys_code), 64'h8_0000_0000);
        key(8'hF0);
        key(8'h1C);
        check("break_other", 64'(keys_code), 64'h8_0000_0000);
        check("two_strobes", 64'(strobe_cnt - s0), 64'd2);
        key(8'hF0);
        key(8'h46);
        check("break_9", 64'(keys_code), 64'h0);

        s0 = strobe_cnt;
        e0 = err_cnt;
        send_frame(8'h16, 1'b1, 1'b0, 11);
`ifdef PS2_PARITY_CHECK_EN
        check("par_keys", 64'(keys_code), 64'h0);
        check("par_err", 64'(err_cnt - e0), 64'd1);
`else
        check("par_keys", 64'(keys_code), 64'h0_0800_0000);
        check("par_err", 64'(err_cnt - e0), 64'd0);
        check("par_strobe", 64'(strobe_cnt - s0), 64'd1);
        key(8'hF0);
        key(8'h16);
`endif
        check("par_clear", 64'(keys_code), 64'h0);

        key(8'hE0);
        key(8'h1C);
        check("ext_ignored", 64'(keys_code), 64'h0);
        key(8'h1C);
        check("ext_cleared", 64'(keys_code), 64'h1);
        key(8'hF0);
        key(8'h1C);
        key(8'h55);
        check("unmapped", 64'(keys_code), 64'h0);

        e0 = err_cnt;
        send_frame(8'h1C, 1'b0, 1'b0, 4);
        repeat (TO + 10) @(posedge clk);
        key(8'h15);
        check("timeout_recover", 64'(keys_code), 64'h0_0001_0000);
        check("timeout_noerr", 64'(err_cnt - e0), 64'd0);

        e0 = err_cnt;
        s0 = strobe_cnt;
        send_frame(8'h1C, 1'b0, 1'b1, 11);
        check("stop_bad_keys", 64'(keys_code), 64'h0_0001_0000);
        check("stop_bad_err", 64'(err_cnt - e0), 64'd1);
        check("stop_bad_nostrobe", 64'(strobe_cnt - s0), 64'd0);

        key(8'hF0);
        send_frame(8'h1A, 1'b0, 1'b0, 5);
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("midrst_keys", 64'(keys_code), 64'h0);
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        key(8'h1A);
        check("after_rst_make", 64'(keys_code), 64'h0_0200_0000);

        check("no_overlap", 64'(overlap_cnt), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/ps2_key_decoder.md
# ps2_key_decoder

Receives the raw PS/2 keyboard line, deframes scan-code set 2 bytes, and tracks make/break sequences for the 36 game keys (A–Z, 0–9). It produces the 36-bit one-hot `keys_code` vector consumed by `target` and the rest of the Battleship input path. It sits between the board's PS/2 pins and the target-selection logic, and is the only block that touches the PS/2 protocol.

## Interface
- `TIMEOUT_CYCLES`, default 100000: `clk` cycles without a `ps2_clk` falling edge before a partial frame is aborted (1 ms at 100 MHz).
- `clk`  in  1  system clock, rising-edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `ps2_clk`  in  1  raw PS/2 clock pin, asynchronous to `clk`.
- `ps2_data`  in  1  raw PS/2 data pin, asynchronous to `clk`.
- `keys_code`  out  36  one-hot key currently held.
  - Bits 0–25 are A–Z.
  - Bits 26–35 are 0–9.
  - All-zero means no tracked key is held.
- `key_strobe`  out  1  one-cycle pulse whenever `keys_code` changes to a nonzero value.
- `frame_err`  out  1  one-cycle pulse when a frame is rejected.

## Operation
- Both pins are synchronized with 2 flops. A falling edge is registered when the previous synced `ps2_clk` is 1 and the current is 0. On that cycle the bit is sampled from synced data.
- Frame FSM states: IDLE → DATA → PARITY → STOP → IDLE.
  - IDLE: a falling edge with data=0 goes to DATA. With data=1 it raises `frame_err` and stays in IDLE.
  - DATA: 8 bits, LSB first; a 3-bit counter moves to PARITY after bit 7.
  - PARITY: sample the parity bit.
  - STOP: data must be 1. Otherwise pulse `frame_err` and discard the byte. Return to IDLE either way.
- Timeout: a counter clears on every falling edge and runs while the FSM is not IDLE. When it reaches `TIMEOUT_CYCLES`, the FSM forces IDLE and discards the partial byte. No `frame_err` is raised.
- Byte layer, applied to each accepted byte:
  - 0xF0 sets `brk`.
  - 0xE0 sets `ext`.
  - Any other byte is a code byte. After handling it, `brk` and `ext` are cleared.
- Code byte handling:
  - If `ext`=1, the byte is ignored entirely.
  - If the byte is not in the key map, it is ignored.
  - Make (`brk`=0): `keys_code` becomes that key's one-hot value. `key_strobe` pulses only if the value differs from the current one, so typematic repeats give no strobe.
  - Break (`brk`=1): `keys_code` clears to 0 only if the released key equals the current `keys_code`. Otherwise there is no change.
- Key map (set 2), bit 0 upward: A 1C, B 32, C 21, D 23, E 24, F 2B, G 34, H 33, I 43, J 3B, K 42, L 4B, M 3A, N 31, O 44, P 4D, Q 15, R 2D, S 1B, T 2C, U 3C, V 2A, W 1D, X 22, Y 35, Z 1A, 0 45, 1 16, 2 1E, 3 26, 4 25, 5 2E, 6 36, 7 3D, 8 3E, 9 46.
- `keys_code` is never multi-hot.

## Timing
- Reset (async assert, sync-safe deassert) sets:
  - `keys_code`=0, `key_strobe`=0, `frame_err`=0.
  - FSM=IDLE, `brk`=0, `ext`=0, synchronizers=1, timeout counter=0.
- Pin-to-edge-detect latency: 3 `clk` cycles after the `ps2_clk` pin falls.
- If the stop-bit edge is detected in cycle N:
  - `keys_code`, `key_strobe` and the `brk`/`ext` updates all take effect at edge N+1.
  - `frame_err` for a bad stop bit asserts at N+1 for exactly one cycle.
- `key_strobe` and `frame_err` are never high in the same cycle.
- Reset mid-frame drops the partial byte and any pending `brk`/`ext`.
- A timeout followed by a clean frame decodes normally.

## Configuration
- `PS2_PARITY_CHECK_EN` defined: the parity bit must make data+parity odd. On failure, pulse `frame_err` at N+1 and discard the byte; `brk`/`ext` are unchanged.
- Undefined: the parity bit is sampled and ignored. Only the start and stop bits are checked.

## Test plan
- Send frame 0x1C → `keys_code`=36'h0_0000_0001 and one `key_strobe` pulse. Resend 0x1C → no change and no strobe.
- Send 0x1C, then F0 1C → `keys_code` returns to 0 and no strobe occurs on the release.
- Send 0x1C, 0x46, then F0 1C → `keys_code`=36'h8_0000_0000 (bit 35) throughout the A release.
- With `PS2_PARITY_CHECK_EN`, send 0x16 with even parity → `frame_err` pulses once and `keys_code` is unchanged. Without the macro → `keys_code`=bit 27.
- Send E0 1C → `keys_code` stays 0. Send 4 bits of a frame, idle for `TIMEOUT_CYCLES`+10, then a full 0x15 frame → `keys_code`=bit 16.
- Assert `rst_n`=0 mid-frame after F0 has been received, release it, then send 0x1A → `keys_code`=bit 25 (make, not break).
